// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: opcode-driven next-PC selection, vector
// fetch on reset/interrupt, stall hold, RET stack wait and illegal-opcode flag.
module pc_sequencer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_FLAGS = 4,
    parameter int unsigned RST_VEC   = 0,
    parameter int unsigned INT_VEC   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [7:0]           opcode,
    input  logic [NUM_FLAGS-1:0] ccr,
    input  logic                 stall,
    input  logic                 irq,
    input  logic [ADDR_W-1:0]    rb_data,
    input  logic [ADDR_W-1:0]    stack_data,
    input  logic                 stack_valid,
    input  logic [ADDR_W-1:0]    vec_rdata,
    output logic [ADDR_W-1:0]    pc,
    output logic                 vec_req,
    output logic [ADDR_W-1:0]    vec_addr,
    output logic                 flush,
    output logic                 int_ack,
    output logic [ADDR_W-1:0]    int_ret_pc,
    output logic                 illegal
);

    localparam logic [1:0] VEC_REQ  = 2'd0;
    localparam logic [1:0] VEC_LOAD = 2'd1;
    localparam logic [1:0] RUN      = 2'd2;
    localparam logic [1:0] RET_WAIT = 2'd3;

    localparam logic SEL_RST = 1'b0;
    localparam logic SEL_INT = 1'b1;

    logic [1:0]        state, state_nxt;
    logic              vec_sel, vec_sel_nxt;
    logic              int_pend, int_pend_nxt;
    logic [ADDR_W-1:0] pc_nxt, int_ret_pc_nxt, vec_addr_nxt;
    logic              vec_req_nxt, flush_nxt, int_ack_nxt, illegal_nxt;

    // Opcode decode results for the instruction presented this cycle
    logic [ADDR_W-1:0] dec_target;
    logic              dec_redirect;
    logic              dec_wait;
    logic              dec_bad;
    logic              int_want;

    assign int_want = int_pend | irq;

    // Next-PC decode from the opcode class
    always_comb begin
        dec_target   = pc + ADDR_W'(1);
        dec_redirect = 1'b0;
        dec_wait     = 1'b0;
        dec_bad      = 1'b0;
        case (opcode[7:4])
            4'h9: begin
                if (ccr[opcode[3:2]]) begin
                    dec_target   = rb_data;
                    dec_redirect = 1'b1;
                end
            end
            4'hA: begin
                if (!ccr[0]) begin
                    dec_target   = rb_data;
                    dec_redirect = 1'b1;
                end
            end
            4'hB: begin
                if (!opcode[3]) begin
                    dec_target   = rb_data;
                    dec_redirect = 1'b1;
                end else if (stack_valid) begin
                    dec_target   = stack_data;
                    dec_redirect = 1'b1;
                end else begin
                    dec_wait = 1'b1;
                end
            end
            4'hC: begin
                if (opcode[3:2] != 2'd3) dec_target = pc + ADDR_W'(2);
                else                     dec_bad    = 1'b1;
            end
            4'hF:    dec_bad = 1'b1;
            default: ;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt      = state;
        vec_sel_nxt    = vec_sel;
        int_pend_nxt   = int_pend | irq;
        pc_nxt         = pc;
        int_ret_pc_nxt = int_ret_pc;
        vec_addr_nxt   = vec_addr;
        vec_req_nxt    = 1'b0;
        flush_nxt      = 1'b0;
        int_ack_nxt    = 1'b0;
        illegal_nxt    = 1'b0;
        case (state)
            VEC_REQ: begin
                vec_req_nxt  = 1'b1;
                vec_addr_nxt = (vec_sel == SEL_INT) ? ADDR_W'(INT_VEC) : ADDR_W'(RST_VEC);
                state_nxt    = VEC_LOAD;
            end
            VEC_LOAD: begin
                pc_nxt      = vec_rdata;
                flush_nxt   = 1'b1;
                int_ack_nxt = (vec_sel == SEL_INT);
                state_nxt   = RUN;
            end
            RUN: begin
                if (instr_valid && !stall) begin
                    if (dec_wait) begin
                        state_nxt = RET_WAIT;
                    end else begin
                        illegal_nxt = dec_bad;
                        // An interrupt take suppresses the branch flush; VEC_LOAD flushes instead
                        if (int_want) begin
                            int_ret_pc_nxt = dec_target;
                            vec_sel_nxt    = SEL_INT;
                            int_pend_nxt   = 1'b0;
                            state_nxt      = VEC_REQ;
                        end else begin
                            pc_nxt    = dec_target;
                            flush_nxt = dec_redirect;
                        end
                    end
                end
            end
            RET_WAIT: begin
                if (stack_valid) begin
                    if (int_want) begin
                        int_ret_pc_nxt = stack_data;
                        vec_sel_nxt    = SEL_INT;
                        int_pend_nxt   = 1'b0;
                        state_nxt      = VEC_REQ;
                    end else begin
                        pc_nxt    = stack_data;
                        flush_nxt = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = VEC_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= VEC_REQ;
            vec_sel    <= SEL_RST;
            int_pend   <= 1'b0;
            pc         <= '0;
            int_ret_pc <= '0;
            vec_addr   <= '0;
            vec_req    <= 1'b0;
            flush      <= 1'b0;
            int_ack    <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_nxt;
            vec_sel    <= vec_sel_nxt;
            int_pend   <= int_pend_nxt;
            pc         <= pc_nxt;
            int_ret_pc <= int_ret_pc_nxt;
            vec_addr   <= vec_addr_nxt;
            vec_req    <= vec_req_nxt;
            flush      <= flush_nxt;
            int_ack    <= int_ack_nxt;
            illegal    <= illegal_nxt;
        end
    end

endmodule
